// File: rtl/multdiv_sequencer.sv
// Sequential signed 32x32 multiply (radix-2 shift-add) and restoring divide, one bit per cycle.
// Define MULTDIV_DIV_EN to build the divider; without it a divide start returns an exception.
module multdiv_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef MULTDIV_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] mag(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic        neg_q, neg_d;
    logic [31:0] opa_q, opa_d;      // multiplicand / divisor magnitude
    logic [31:0] hi_q, hi_d;        // product high half / partial remainder
    logic [31:0] lo_q, lo_d;        // multiplier -> product low half / dividend -> quotient
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic        start;
    logic [32:0] add_sum;
    logic [63:0] prod_mag;
    logic [63:0] prod_signed;
`ifdef MULTDIV_DIV_EN
    logic [32:0] trial;
    logic [31:0] quot_signed;
`endif

    assign start = ctrl_MULT | ctrl_DIV;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves a latch behind.
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        err_d    = err_q;
        neg_d    = neg_q;
        opa_d    = opa_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        exc_d    = exc_q;

        add_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : 33'd0);
        prod_mag    = {hi_q, lo_q};
        prod_signed = neg_q ? (~prod_mag + 64'd1) : prod_mag;
`ifdef MULTDIV_DIV_EN
        // hi_q stays below the divisor, so its MSB is zero and the shifted value fits 33 bits.
        trial       = {hi_q, lo_q[31]} - {1'b0, opa_q};
        quot_signed = neg_q ? (~lo_q + 32'd1) : lo_q;
`endif

        if (err_q) begin
            state_d  = ST_DONE;
            result_d = 32'd0;
            exc_d    = 1'b1;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_MUL: begin
                    if (!last_q) begin
                        hi_d   = add_sum[32:1];
                        lo_d   = {add_sum[0], lo_q[31:1]};
                        cnt_d  = cnt_q + 5'd1;
                        last_d = (cnt_q == 5'd31);
                    end else begin
                        state_d  = ST_DONE;
                        last_d   = 1'b0;
                        result_d = prod_signed[31:0];
                        exc_d    = (prod_signed[63:32] != {32{prod_signed[31]}});
                    end
                end
`ifdef MULTDIV_DIV_EN
                ST_DIV: begin
                    if (!last_q) begin
                        hi_d   = trial[32] ? {hi_q[30:0], lo_q[31]} : trial[31:0];
                        lo_d   = {lo_q[30:0], ~trial[32]};
                        cnt_d  = cnt_q + 5'd1;
                        last_d = (cnt_q == 5'd31);
                    end else begin
                        state_d  = ST_DONE;
                        last_d   = 1'b0;
                        result_d = quot_signed;
                        // Only a positive quotient of magnitude 2^31 overflows.
                        exc_d    = ~neg_q & lo_q[31];
                    end
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end

        // A start is honoured in every state; an operation in flight is simply dropped.
        if (start) begin
            cnt_d  = 5'd0;
            last_d = 1'b0;
            err_d  = 1'b0;
            hi_d   = 32'd0;
            neg_d  = data_operandA[31] ^ data_operandB[31];
            if (ctrl_MULT) begin
                state_d = ST_MUL;
                opa_d   = mag(data_operandA);
                lo_d    = mag(data_operandB);
            end else begin
`ifdef MULTDIV_DIV_EN
                if (data_operandB == 32'd0) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_DIV;
                    opa_d   = mag(data_operandB);
                    lo_d    = mag(data_operandA);
                end
`else
                state_d = ST_IDLE;
                err_d   = 1'b1;
`endif
            end
        end

        // Suppress a second pulse if DONE is re-entered straight from DONE.
        rdy_d = (state_d == ST_DONE) && !rdy_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            neg_q    <= 1'b0;
            opa_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            err_q    <= err_d;
            neg_q    <= neg_d;
            opa_q    <= opa_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        busy = (state_q == ST_MUL);
`ifdef MULTDIV_DIV_EN
        if (state_q == ST_DIV) busy = 1'b1;
`endif
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_r = 32'd0;

    multdiv_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 = multiply, 1 = divide, 2 = both controls high (multiply)
    function automatic void model(input int mode, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        longint p;
        int     sa;
        int     sb;
        int     lo32;
        sa = a;
        sb = b;
        if (mode != 1) begin
            p    = longint'(sa) * longint'(sb);
            lo32 = p[31:0];
            r    = p[31:0];
            e    = (p != longint'(lo32));
            lat  = 33;
        end else begin
`ifdef MULTDIV_DIV_EN
            if (b == 32'd0) begin
                r = 32'd0; e = 1'b1; lat = 1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = 32'h8000_0000; e = 1'b1; lat = 33;
            end else begin
                r = sa / sb; e = 1'b0; lat = 33;
            end
`else
            r = 32'd0; e = 1'b1; lat = 1;
`endif
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic start_op(input int mode, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = (mode != 1);
        ctrl_DIV      = (mode != 0);
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic run_op(input int mode, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] er;
        logic        ee;
        int          elat;
        int          lat;
        model(mode, a, b, er, ee, elat);
        start_op(mode, a, b);
        if (elat == 33) check({tag, " busy_run"}, 64'(busy), 64'd1);
        lat = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) lat = n;
            else if (n == 16) check({tag, " hold"}, 64'(data_result), 64'(last_r));
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " result"}, 64'(data_result), 64'(er));
        check({tag, " exception"}, 64'(data_exception), 64'(ee));
        check({tag, " busy_done"}, 64'(busy), 64'd0);
        last_r = er;
        @(posedge clock);
        @(negedge clock);
        check({tag, " rdy_single"}, 64'(data_resultRDY), 64'd0);
        check({tag, " result_held"}, 64'(data_result), 64'(er));
    endtask

    initial begin
        int          mode;
        int          mid_mode;
        logic [31:0] a;
        logic [31:0] b;

        #2 reset_n = 1'b0;
        @(negedge clock);
        check("rst result", 64'(data_result), 64'd0);
        check("rst exception", 64'(data_exception), 64'd0);
        check("rst rdy", 64'(data_resultRDY), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(posedge clock);
        @(negedge clock);
        check("rst ignores start", 64'(busy), 64'd0);
        ctrl_MULT = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        run_op(0, 32'd7, -32'sd6, "mul 7*-6");
        run_op(0, 32'h0001_0000, 32'h0001_0000, "mul overflow");
        run_op(1, -32'sd100, 32'd7, "div -100/7");
        run_op(1, 32'd5, 32'd0, "div by zero");
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
        run_op(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "both ctrl");
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, "mul min*-1");
        run_op(0, 32'hFFFF_FFFF, 32'h8000_0000, "mul -1*min");
        run_op(1, 32'd10, 32'd2, "div 10/2");
        run_op(0, 32'd10, 32'd2, "mul 10*2");

        start_op(0, 32'd3, 32'd4);
        repeat (9) @(negedge clock);
        run_op(0, 32'd5, 32'd6, "abort restart");

`ifdef MULTDIV_DIV_EN
        mid_mode = 1;
`else
        mid_mode = 0;
`endif
        start_op(mid_mode, -32'sd100, 32'd7);
        repeat (20) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst result", 64'(data_result), 64'd0);
        check("midrst exception", 64'(data_exception), 64'd0);
        check("midrst rdy", 64'(data_resultRDY), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        last_r = 32'd0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        run_op(0, 32'd9, 32'd9, "post reset 9*9");

        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: begin
                    a = 32'($urandom_range(0, 2000)) - 32'd1000;
                    b = 32'($urandom_range(0, 2000)) - 32'd1000;
                end
                1: begin
                    a = $urandom;
                    b = $urandom;
                end
                2: begin
                    a = $urandom;
                    b = 32'($urandom_range(0, 3)) - 32'd1;
                end
                default: begin
                    a = $urandom;
                    b = 32'd0;
                end
            endcase
            run_op(mode, a, b, $sformatf("rnd%0d m%0d", i, mode));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
